// File: rtl/mux21_arb_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
// Holds the FSM state enum and the default WIDTH / MAX_HOLD values.
package mux21_arb_pkg;

  localparam int ARB_WIDTH_DEF    = 8;
  localparam int ARB_MAX_HOLD_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/Mux21.sv
// Single-bit 2:1 multiplexer used as the arbiter datapath cell.
// Ports: out = in[sel]; in[1:0] are the candidates; sel picks one.
module Mux21 (
  output logic       out,
  input  logic [1:0] in,
  input  logic       sel
);

  assign out = in[sel];

endmodule

// File: rtl/mux21_arbiter.sv
// Two-requester arbiter sharing one valid/ready channel via Mux21 cells.
// Ports: clk, rst_n (async low); in0_*/in1_* upstream valid/data/last/ready;
// out_* downstream valid/data/last/ready; sel mux select; busy grant active.
// Build option MUX21_ARB_RR_EN: round-robin tie-break (else in0 priority).
module mux21_arbiter
  import mux21_arb_pkg::*;
#(
  parameter int WIDTH    = ARB_WIDTH_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  arb_state_t state;
  arb_state_t state_n;

  logic [CW-1:0] cnt;
  logic          req_any;
  logic          tie_win;
  logic          win;
  logic          sel_valid;
  logic          beat;
  logic          rel;

  logic [WIDTH:0] bus0;
  logic [WIDTH:0] bus1;
  logic [WIDTH:0] mux_out;

  assign req_any = in0_valid | in1_valid;

`ifdef MUX21_ARB_RR_EN
  logic last_gnt;

  // Reset to 1 so the first tie after reset goes to in0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && req_any) begin
      last_gnt <= win;
    end
  end

  assign tie_win = ~last_gnt;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (in0_valid && !in1_valid): win = 1'b0;
      (!in0_valid && in1_valid): win = 1'b1;
      (in0_valid && in1_valid):  win = tie_win;
      default:                   win = 1'b0;
    endcase
  end

  // Datapath: {last, data} per requester, one Mux21 per bit.
  assign bus0 = {in0_last, in0_data};
  assign bus1 = {in1_last, in1_data};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
    Mux21 u_mux (
      .out (mux_out[i]),
      .in  ({bus1[i], bus0[i]}),
      .sel (sel)
    );
  end

  assign sel_valid = sel ? in1_valid : in0_valid;
  assign beat      = out_valid & out_ready;
  // Release on packet end or on the beat that reaches MAX_HOLD.
  assign rel       = beat & (out_last | (cnt == CNT_LAST));
  assign busy      = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_any) state_n = GRANT;
      GRANT:   if (rel)     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (req_any) begin
        sel <= win;
        cnt <= '0;
      end
    end else if (beat) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (state == GRANT) begin
      out_valid = sel_valid;
      out_data  = mux_out[WIDTH-1:0];
      out_last  = mux_out[WIDTH];
      in0_ready = ~sel & out_ready;
      in1_ready = sel & out_ready;
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Self-checking bench for mux21_arbiter: directed scenarios plus
// randomized traffic checked against a transaction-level model.
module tb_mux21_arbiter;

  localparam int W  = 8;
  localparam int MH = 15;

`ifdef MUX21_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in1_valid;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_last, in1_last;
  logic         in0_ready, in1_ready;
  logic         out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  logic         sel, busy;

  always #5 clk = ~clk;

  mux21_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction model: who owns the channel and how many beats it moved.
  bit m_busy;
  bit m_owner;
  bit m_last;
  int m_beats;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_beats = 0;
  endtask

  task automatic clear_inputs();
    in0_valid = 0; in0_data = '0; in0_last = 0;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    out_ready = 0;
  endtask

  // Advance one clock, updating the model with the pre-edge inputs.
  task automatic tick();
    bit v, l;
    @(posedge clk);
    if (!m_busy) begin
      if (in0_valid || in1_valid) begin
        if (in0_valid && in1_valid) m_owner = RR ? !m_last : 1'b0;
        else m_owner = in1_valid;
        m_last  = m_owner;
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end else begin
      v = m_owner ? in1_valid : in0_valid;
      l = m_owner ? in1_last : in0_last;
      if (v && out_ready) begin
        m_beats++;
        if (l || m_beats == MH) m_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    in0_valid = 1; in1_valid = 1; out_ready = 1;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL rst_sel got %b exp 0", sel); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_tests++; if ({in1_ready, in0_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b%b exp 00", in1_ready, in0_ready); end
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_packet();
    logic [W-1:0] pkt [3];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    do_reset();
    out_ready = 1; in0_valid = 1; in0_data = pkt[0];
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pkt_idle_busy got %b exp 0", busy); end
    n_tests++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL pkt_idle_rdy got %b exp 0", in0_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      in0_data = pkt[i];
      in0_last = (i == 2);
      #1;
      n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL pkt_sel[%0d] got %b exp 0", i, sel); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pkt_busy[%0d] got %b exp 1", i, busy); end
      n_tests++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL pkt_rdy[%0d] got %b exp 1", i, in0_ready); end
      n_tests++; if (out_data !== pkt[i]) begin n_fail++; $display("FAIL pkt_data[%0d] got %h exp %h", i, out_data, pkt[i]); end
      n_tests++; if (out_last !== (i == 2)) begin n_fail++; $display("FAIL pkt_last[%0d] got %b exp %b", i, out_last, i == 2); end
      tick();
    end
    in0_valid = 0; in0_last = 0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pkt_release got busy %b exp 0", busy); end
  endtask

  task automatic test_alternate();
    logic [W-1:0] q [$];
    logic [W-1:0] exp;
    do_reset();
    out_ready = 1;
    in0_valid = 1; in0_data = 8'hA0; in0_last = 1;
    in1_valid = 1; in1_data = 8'hB0; in1_last = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++; if (out_valid !== i[0]) begin n_fail++; $display("FAIL alt_valid[%0d] got %b exp %b", i, out_valid, i[0]); end
      if (out_valid === 1'b1) q.push_back(out_data);
      tick();
    end
    n_tests++; if (q.size() != 4) begin n_fail++; $display("FAIL alt_count got %0d exp 4", q.size()); end
    for (int k = 0; k < q.size(); k++) begin
      exp = (RR && k[0]) ? 8'hB0 : 8'hA0;
      n_tests++; if (q[k] !== exp) begin n_fail++; $display("FAIL alt_data[%0d] got %h exp %h", k, q[k], exp); end
    end
  endtask

  task automatic test_max_hold();
    int  sent;
    bit  bl [24];
    do_reset();
    out_ready = 1;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      in1_valid = (sent < 20);
      in1_data  = W'(sent);
      #1;
      bl[c] = busy;
      if (out_valid === 1'b1 && in1_ready === 1'b1) begin
        n_tests++; if (out_data !== W'(sent)) begin n_fail++; $display("FAIL hold_data got %h exp %h", out_data, W'(sent)); end
        sent++;
      end
      tick();
    end
    n_tests++; if (sent != 20) begin n_fail++; $display("FAIL hold_beats got %0d exp 20", sent); end
    n_tests++; if (bl[15] !== 1'b1) begin n_fail++; $display("FAIL hold_busy15 got %b exp 1", bl[15]); end
    n_tests++; if (bl[16] !== 1'b0) begin n_fail++; $display("FAIL hold_bubble got %b exp 0", bl[16]); end
    n_tests++; if (bl[17] !== 1'b1) begin n_fail++; $display("FAIL hold_regrant got %b exp 1", bl[17]); end
    n_tests++; if (sel !== 1'b1) begin n_fail++; $display("FAIL hold_sel got %b exp 1", sel); end
  endtask

  task automatic test_stall();
    do_reset();
    in0_valid = 1; in0_data = 8'h5A; out_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy[%0d] got %b exp 0", i, in0_ready); end
      n_tests++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL stall_data[%0d] got %h exp 5a", i, out_data); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, out_valid); end
      tick();
    end
    out_ready = 1;
    #1;
    n_tests++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_resume got %b exp 1", in0_ready); end
    tick();
    for (int i = 0; i < MH - 2; i++) tick();
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_early_rel got busy %b exp 1", busy); end
    tick();
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_cnt got busy %b exp 0", busy); end
  endtask

  task automatic test_drop();
    do_reset();
    out_ready = 1;
    in0_valid = 1; in0_data = 8'hC1;
    in1_valid = 1; in1_data = 8'hD1; in1_last = 1;
    tick();
    #1;
    n_tests++; if (out_data !== 8'hC1) begin n_fail++; $display("FAIL drop_first got %h exp c1", out_data); end
    tick();
    in0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL drop_sel[%0d] got %b exp 0", i, sel); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid[%0d] got %b exp 0", i, out_valid); end
      n_tests++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL drop_rdy1[%0d] got %b exp 0", i, in1_ready); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy[%0d] got %b exp 1", i, busy); end
      tick();
    end
    in0_valid = 1; in0_data = 8'hC2; in0_last = 1;
    #1;
    n_tests++; if (out_data !== 8'hC2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL drop_resume got %b/%h exp 1/c2", out_valid, out_data); end
    tick();
    in0_valid = 0; in1_valid = 0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_end got busy %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1;
    in1_valid = 1; in1_data = 8'h77;
    tick();
    #1;
    n_tests++; if (sel !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre got sel %b busy %b exp 1 1", sel, busy); end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    n_tests++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL arst_rdy got %b exp 0", in1_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy); end
    n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL arst_sel got %b exp 0", sel); end
    @(negedge clk);
    rst_n = 1;
    in0_valid = 1; in0_data = 8'h66; in0_last = 1; in1_last = 1;
    tick();
    #1;
    n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL arst_tie got sel %b exp 0", sel); end
    n_tests++; if (out_data !== 8'h66) begin n_fail++; $display("FAIL arst_data got %h exp 66", out_data); end
  endtask

  task automatic test_random();
    bit           ev, el, sv;
    logic [W-1:0] ed;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in0_valid = ($urandom_range(0, 9) < 7);
      in1_valid = ($urandom_range(0, 9) < 7);
      in0_data  = W'($urandom);
      in1_data  = W'($urandom);
      in0_last  = ($urandom_range(0, 11) == 0);
      in1_last  = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 9) < 8);
      #1;
      sv = m_owner ? in1_valid : in0_valid;
      ev = m_busy && sv;
      el = m_owner ? in1_last : in0_last;
      ed = m_owner ? in1_data : in0_data;
      n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d got %b exp %b", c, busy, m_busy); end
      n_tests++; if (sel !== m_owner) begin n_fail++; $display("FAIL rnd_sel@%0d got %b exp %b", c, sel, m_owner); end
      n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid@%0d got %b exp %b", c, out_valid, ev); end
      n_tests++; if (in0_ready !== (m_busy && !m_owner && out_ready)) begin n_fail++; $display("FAIL rnd_rdy0@%0d got %b", c, in0_ready); end
      n_tests++; if (in1_ready !== (m_busy && m_owner && out_ready)) begin n_fail++; $display("FAIL rnd_rdy1@%0d got %b", c, in1_ready); end
      if (ev) begin
        n_tests++; if (out_data !== ed || out_last !== el) begin n_fail++; $display("FAIL rnd_data@%0d got %h/%b exp %h/%b", c, out_data, out_last, ed, el); end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_packet();
    test_alternate();
    test_max_hold();
    test_stall();
    test_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
